conversor_bcd: RTL and testbench

CONVERSOR_BCD -- requirements
Module: conversor_bcd

---
 rtl/conversor_bcd.sv | 88 ++++++++
 tb/tb_conversor_bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm.
// One bit is consumed per clock; a new result appears WIDTH cycles after start is accepted.
module conversor_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]    scratch_q;
  logic [SW-1:0]    bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [SW-1:0]    scratch_d;
  logic [WIDTH-1:0] shift_d;

  // Add 3 to every digit that would overflow past 9 once doubled by the shift.
  function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    {scratch_d, shift_d} = {dabble_adjust(scratch_q), shift_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CW'(1);
          // Last shift: publish the fully shifted scratch, not the pre-shift value.
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: vector table, multi-cycle corner sequences
// and random values checked against a decimal reference model.
module tb_conversor_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int checks;
  int failures;

  conversor_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: each digit extracted with plain division and modulo.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [19:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Accept one conversion, scramble bin afterwards, and check timing, hold and result.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] exp, input string name);
    int n;
    logic busy_ok;
    logic hold_ok;
    logic [19:0] prev;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    prev  = bcd;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    n = 0;
    do begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (bcd !== prev) hold_ok = 1'b0;
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    chk({name, "_latency"}, 64'(n), 64'd16);
    chk({name, "_busy_during"}, 64'(busy_ok), 64'd1);
    chk({name, "_bcd_hold"}, 64'(hold_ok), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({name, "_bcd"}, 64'(bcd), 64'(exp));
    chk({name, "_digits"}, 64'(digits_ok(bcd)), 64'd1);
    tick();
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int extra;
    logic [15:0] rv;
    checks   = 0;
    failures = 0;

    vecs[0] = '{16'd1234,  20'h01234};
    vecs[1] = '{16'hFFFF,  20'h65535};
    vecs[2] = '{16'd0,     20'h00000};
    vecs[3] = '{16'd9,     20'h00009};
    vecs[4] = '{16'd10,    20'h00010};
    vecs[5] = '{16'd99,    20'h00099};
    vecs[6] = '{16'd59999, 20'h59999};
    vecs[7] = '{16'd40960, 20'h40960};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_bcd", 64'(bcd), 64'd0);

    for (int i = 0; i < 8; i++) run_conv(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));

    // start re-pulsed mid-conversion must be ignored
    bin = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bin = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 5;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_restart_latency", 64'(n), 64'd16);
    chk("busy_restart_bcd", 64'(bcd), 64'h01234);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    chk("busy_restart_no_second_done", 64'(extra), 64'd0);

    // back-to-back with start held high
    bin = 16'd100;
    start = 1'b1;
    tick();
    bin = 16'd200;
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 40);
    chk("b2b_first_latency", 64'(n), 64'd16);
    chk("b2b_first_bcd", 64'(bcd), 64'h00100);
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 40);
    chk("b2b_period", 64'(n), 64'd17);
    chk("b2b_second_bcd", 64'(bcd), 64'h00200);
    start = 1'b0;
    tick();
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_idle", 64'(busy), 64'd0);

    // reset mid-conversion aborts without a done pulse
    bin = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_bcd", 64'(bcd), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("rst_mid_quiet", 64'(extra), 64'd0);
    run_conv(16'd42, 20'h00042, "after_rst");

    // reset wins over a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    bin = 16'd777;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", 64'(busy), 64'd0);
    chk("rst_prio_bcd", 64'(bcd), 64'd0);
    tick();
    chk("rst_prio_still_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      rv = 16'($urandom);
      run_conv(rv, ref_bcd(int'(rv)), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
